// File: rtl/relay_fifo_link.sv
// Relay line link: deserialises peer frames into a FWFT FIFO and frames gated relay_raw samples onto relay_out.
// Latency: stop-bit sample to rx_valid 1 cycle; word completion to start bit 1 cycle.
// Backpressure: rx_ready pops the FIFO; full FIFO drops symbols (rx_overflow), busy TX drops words (tx_overrun).
module relay_fifo_link #(
    parameter int SYM_BITS   = 4,
    parameter int DEPTH      = 8,
    parameter int BIT_DIV    = 8,
    parameter int SAMPLE_DIV = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             hi_simulate_mod_type,
    input  logic [2:0]             mod_type,
    input  logic                   relay_in,
    output logic [SYM_BITS-1:0]    rx_sym,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    input  logic                   relay_raw,
    output logic                   relay_out,
    output logic                   mod_switched,
    output logic                   rx_overflow,
    output logic                   rx_frame_err,
    output logic                   tx_overrun
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int BCW = $clog2(BIT_DIV);
    localparam int SCW = $clog2(SAMPLE_DIV);
    localparam int NW  = $clog2(SYM_BITS + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_DIV - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(BIT_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [2:0] prev_mod;
    logic       inv, inv_flip, flush, fake_reader, l_in;

    assign fake_reader = hi_simulate_mod_type == 3'b101;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_mod     <= '0;
            mod_switched <= 1'b0;
            inv          <= 1'b0;
            inv_flip     <= 1'b0;
        end else begin
            prev_mod     <= mod_type;
            mod_switched <= (prev_mod == 3'b100 && mod_type == 3'b011) ||
                            (prev_mod == 3'b010 && mod_type == 3'b001);
            inv          <= fake_reader;
            inv_flip     <= fake_reader != inv;
        end
    end

    // A polarity change flushes alongside a mode switch so stale line state is never decoded.
    assign flush = mod_switched | inv_flip;
    assign l_in  = relay_in ^ inv;

    rx_state_t           rx_state, rx_state_nxt;
    logic [BCW-1:0]      rx_cnt, rx_cnt_nxt;
    logic [NW-1:0]       rx_bits, rx_bits_nxt;
    logic [SYM_BITS-1:0] rx_shift, rx_shift_nxt;
    logic [SYM_BITS:0]   rx_ext;
    logic                push, frame_bad;

    assign rx_ext = {rx_shift, l_in};

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bits_nxt  = rx_bits;
        rx_shift_nxt = rx_shift;
        push         = 1'b0;
        frame_bad    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt  = '0;
                rx_bits_nxt = '0;
                if (l_in) rx_state_nxt = RX_START;
            end
            RX_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = l_in ? RX_DATA : RX_IDLE;
            end
            RX_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_nxt   = '0;
                rx_shift_nxt = rx_ext[SYM_BITS-1:0];
                rx_bits_nxt  = rx_bits + 1'b1;
                if (rx_bits == NW'(SYM_BITS - 1)) rx_state_nxt = RX_STOP;
            end
            RX_STOP: if (rx_cnt == BIT_LAST) begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = RX_IDLE;
                push         = !l_in;
                frame_bad    = l_in;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bits  <= rx_bits_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    logic [SYM_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]       level_nxt;
    logic [SYM_BITS-1:0] head_nxt;
    logic                full, pop, push_ok;

    assign full      = fifo_level == LW'(DEPTH);
    assign rx_valid  = fifo_level != '0;
    assign pop       = rx_valid && rx_ready && !flush;
    assign push_ok   = push && !flush && (!full || pop);
    assign rd_nxt    = rd_ptr + AW'(pop);
    assign level_nxt = fifo_level + LW'(push_ok) - LW'(pop);
    // rx_sym is a registered head; when the FIFO drains to zero before this push the new symbol is the head.
    assign head_nxt  = (fifo_level == LW'(pop)) ? rx_shift : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rx_sym     <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_nxt;
            fifo_level <= level_nxt;
            if (level_nxt != '0) rx_sym <= head_nxt;
        end
    end

    logic [SCW-1:0]      s_cnt;
    logic [NW-1:0]       a_cnt;
    logic [SYM_BITS-1:0] asm_q, word;
    logic [SYM_BITS:0]   asm_ext;
    logic                g, tick, word_done, tx_busy, load;

    assign g         = relay_raw && mod_type != 3'b010 && mod_type != 3'b100;
    assign tick      = s_cnt == SCW'(SAMPLE_DIV - 1);
    assign asm_ext   = {asm_q, g};
    assign word      = asm_ext[SYM_BITS-1:0];
    assign word_done = tick && a_cnt == NW'(SYM_BITS - 1);
    assign load      = word_done && !tx_busy;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s_cnt <= '0;
            a_cnt <= '0;
            asm_q <= '0;
        end else begin
            s_cnt <= tick ? '0 : s_cnt + 1'b1;
            if (tick) begin
                asm_q <= word;
                a_cnt <= word_done ? '0 : a_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overrun   <= 1'b0;
        end else begin
            if (push && !flush && full && !pop) rx_overflow <= 1'b1;
            if (frame_bad && !flush) rx_frame_err <= 1'b1;
            if (word_done && tx_busy && !flush) tx_overrun <= 1'b1;
        end
    end

    tx_state_t           tx_state, tx_state_nxt;
    logic [BCW-1:0]      tx_cnt, tx_cnt_nxt;
    logic [NW-1:0]       tx_bits, tx_bits_nxt;
    logic [SYM_BITS-1:0] tx_shift, tx_shift_nxt;
    logic [SYM_BITS:0]   tx_ext;
    logic                tx_line, tx_line_nxt;

    assign tx_ext  = {tx_shift, 1'b0};
    assign tx_busy = tx_state != TX_IDLE;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_bits_nxt  = tx_bits;
        tx_shift_nxt = tx_shift;
        tx_line_nxt  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt  = '0;
                tx_bits_nxt = '0;
                if (load) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = word;
                    tx_line_nxt  = 1'b1;
                end
            end
            TX_START: if (tx_cnt == BIT_LAST) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_DATA;
                tx_line_nxt  = tx_shift[SYM_BITS-1];
                tx_shift_nxt = tx_ext[SYM_BITS-1:0];
                tx_bits_nxt  = NW'(1);
            end
            TX_DATA: if (tx_cnt == BIT_LAST) begin
                tx_cnt_nxt = '0;
                if (tx_bits == NW'(SYM_BITS)) begin
                    tx_state_nxt = TX_STOP;
                    tx_line_nxt  = 1'b0;
                end else begin
                    tx_line_nxt  = tx_shift[SYM_BITS-1];
                    tx_shift_nxt = tx_ext[SYM_BITS-1:0];
                    tx_bits_nxt  = tx_bits + 1'b1;
                end
            end
            TX_STOP: if (tx_cnt == BIT_LAST) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bits  <= tx_bits_nxt;
            tx_shift <= tx_shift_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    assign relay_out = tx_line ^ inv;
endmodule
